// File: rtl/common_types_pkg.sv
// Common word-level types shared by the memory-side blocks.
package common_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port instruction/data memory arbiter.
package mem_arb_pkg;

  typedef common_types_pkg::word_t word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int unsigned FAIR_LIMIT_DFLT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto one word-wide RAM port; data has priority.
// Optional instruction-starvation bound enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = FAIR_LIMIT_DFLT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready
);

  if (FAIR_LIMIT == 0) begin : g_bad_fair_limit
    $error("mem_arbiter: FAIR_LIMIT must be non-zero");
  end

  arb_state_t state_q, state_d;
  word_t      addr_q;
  word_t      store_q;
  logic       ren_q;
  logic       wen_q;

  logic d_req;
  logic fair_hit;
  logic take_d;
  logic done;

  assign d_req = dREN | dWEN;
  assign done  = ramready & (state_q != IDLE);

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned FAIR_W = $clog2(FAIR_LIMIT + 1);

  logic [FAIR_W-1:0] fair_cnt_q, fair_cnt_d;

  // A pending fetch that has already lost FAIR_LIMIT times gets the next grant.
  assign fair_hit = iREN & (fair_cnt_q == FAIR_W'(FAIR_LIMIT));

  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (state_q == IDLE) begin
      if (state_d == IGNT) begin
        fair_cnt_d = '0;
      end else if (state_d == DGNT && iREN) begin
        fair_cnt_d = fair_cnt_q + FAIR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  assign fair_hit = 1'b0;
`endif

  assign take_d = d_req & ~fair_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_d) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end
      IGNT, DGNT: begin
        if (ramready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request is latched on grant entry; the RAM access always runs to completion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == DGNT) begin
        addr_q  <= daddr;
        store_q <= dstore;
        ren_q   <= ~dWEN;
        wen_q   <= dWEN;
      end else if (state_q == IDLE && state_d == IGNT) begin
        addr_q  <= iaddr & ~word_t'(3);
        store_q <= '0;
        ren_q   <= 1'b1;
        wen_q   <= 1'b0;
      end else if (done) begin
        ren_q   <= 1'b0;
        wen_q   <= 1'b0;
      end
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  // Completion is seen in the ready cycle itself so the pipeline restarts without delay.
  assign iwait = iREN  & ~((state_q == IGNT) & ramready);
  assign dwait = d_req & ~((state_q == DGNT) & ramready);
  assign iload = ((state_q == IGNT) && ramready && iREN)  ? ramload : '0;
  assign dload = ((state_q == DGNT) && ramready && d_req) ? ramload : '0;

endmodule
